// File: rtl/log_compress.sv
// Three-stage log2 compressor: capture, leading-one detect, Mitchell normalize/pack.
// Valid/ready on both sides; each stage refills whenever it is empty or draining.
module log_compress #(
    parameter int ENV_WIDTH = 32,
    parameter int LOG_WIDTH = 16,
    parameter int INT_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ENV_WIDTH-1:0] env_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LOG_WIDTH-1:0] log_out
);
    localparam int FRAC_BITS = LOG_WIDTH - INT_BITS;
    localparam int FRAC_SH   = ENV_WIDTH - 1 - FRAC_BITS;

    logic                 v1, v2, v3;
    logic [ENV_WIDTH-1:0] d1, d2;
    logic [INT_BITS-1:0]  e2;
    logic                 z2;
    logic [LOG_WIDTH-1:0] d3;

    logic                 adv1, adv2, adv3;
    logic [INT_BITS-1:0]  e_calc;
    logic [INT_BITS-1:0]  shamt;
    logic [FRAC_BITS-1:0] frac;
    logic [LOG_WIDTH-1:0] packed_log;

    // Each stage may load when empty or when its occupant moves on this cycle.
    assign adv3     = !v3 || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = !reset && adv1;

    assign out_valid = v3;
    assign log_out   = d3;

    always_comb begin
        e_calc = '0;
        for (int unsigned i = 0; i < ENV_WIDTH; i++) begin
            if (d1[i]) e_calc = INT_BITS'(i);
        end
    end

    // Leading one lands on the MSB; the bits below it are the truncated fraction.
    always_comb begin
        shamt      = INT_BITS'(ENV_WIDTH - 1) - e2;
        frac       = FRAC_BITS'((d2 << shamt) >> FRAC_SH);
        packed_log = z2 ? '0 : {e2, frac};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
            e2 <= '0;
            z2 <= 1'b0;
            d3 <= '0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) d1 <= env_in;
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    d2 <= d1;
                    e2 <= e_calc;
                    z2 <= (d1 == '0);
                end
            end
            if (adv3) begin
                v3 <= v2;
                if (v2) d3 <= packed_log;
            end
        end
    end
endmodule

// File: tb/tb_log_compress.sv
// Bench for log_compress: directed vectors, handshake corner cases and a
// randomized run scored against an arithmetic log2 model.
module tb_log_compress;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] env_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] log_out;

    int checks = 0;
    int errors = 0;
    int in_hs = 0;
    int out_hs = 0;
    int dropped = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [31:0] env;
        logic [15:0] exp;
    } vec_t;

    log_compress #(.ENV_WIDTH(32), .LOG_WIDTH(16), .INT_BITS(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .env_in(env_in), .out_valid(out_valid), .out_ready(out_ready), .log_out(log_out)
    );

    always #5 clk = ~clk;

    // log2 with exponent = floor(log2 x) and fraction = (x - 2^e) / 2^e, truncated to 10 bits.
    function automatic logic [15:0] ref_log(input logic [31:0] x);
        longint unsigned v, p, fr;
        int e;
        if (x == 0) return 16'h0000;
        v = 64'(x);
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        p = 64'd1 << e;
        fr = ((v - p) * 64'd1024) / p;
        return 16'((longint'(e) * 1024) + longint'(fr));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshakes take effect on the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (reset) begin
            dropped += sb_q.size();
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_hs++;
                if (sb_q.size() == 0) check("sb_unexpected_output", 32'(log_out), 32'hFFFF_FFFF);
                else check("sb_order_value", 32'(log_out), 32'(sb_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                in_hs++;
                sb_q.push_back(ref_log(env_in));
            end
        end
    end

    task automatic single(input logic [31:0] x, input logic [15:0] exp);
        int cnt;
        @(posedge clk); #1;
        in_valid = 1'b1; env_in = x; out_ready = 1'b1;
        cnt = 0;
        while (cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) in_valid = 1'b0;
            if (out_valid) break;
        end
        check($sformatf("latency_%0h", x), 32'(cnt), 32'd3);
        check($sformatf("value_%0h", x), 32'(log_out), 32'(exp));
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        in_valid = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[6];
        logic [31:0] bp[6];
        int k, acc, cyc;
        logic took;

        vecs[0] = '{32'h0000_0000, 16'h0000};
        vecs[1] = '{32'h0000_0001, 16'h0000};
        vecs[2] = '{32'h0000_0003, 16'h0600};
        vecs[3] = '{32'h0000_0300, 16'h2600};
        vecs[4] = '{32'h0001_0000, 16'h4000};
        vecs[5] = '{32'hFFFF_FFFF, 16'h7FFF};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; env_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_log_out", 32'(log_out), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Directed single samples, also cross-checking the model.
        for (int i = 0; i < 6; i++) begin
            check($sformatf("model_%0d", i), 32'(ref_log(vecs[i].env)), 32'(vecs[i].exp));
            single(vecs[i].env, vecs[i].exp);
        end
        drain();

        // Back-to-back powers of two.
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            env_in = 32'd1 << c;
            out_ready = 1'b1;
            @(negedge clk);
            if (c < 8) check("stream_in_ready", 32'(in_ready), 32'd1);
            if (c >= 3 && c < 11) begin
                check("stream_out_valid", 32'(out_valid), 32'd1);
                check("stream_value", 32'(log_out), 32'((c - 3) * 1024));
            end
            if (c == 11) check("stream_end_idle", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: output stalled for 6 cycles with a continuous stream.
        bp[0] = 32'h5; bp[1] = 32'h80; bp[2] = 32'h1234;
        bp[3] = 32'hFFFF_0000; bp[4] = 32'h7; bp[5] = 32'h4_0000;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; env_in = bp[k]; out_ready = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) k++;
            if (c == 5) check("bp_full_in_ready", 32'(in_ready), 32'd0);
            if (c >= 3) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_value", 32'(log_out), 32'(ref_log(bp[0])));
            end
            @(posedge clk); #1;
        end
        check("bp_accepted", 32'(k), 32'd3);
        for (int c = 6; c < 26 && k < 6; c++) begin
            in_valid = 1'b1; env_in = bp[k]; out_ready = 1'b1;
            @(negedge clk);
            if (c == 6) check("bp_full_accept_emit", 32'(in_ready), 32'd1);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        check("bp_total", 32'(k), 32'd6);
        drain();

        // Bubbles with alternating valid and ready.
        for (int c = 0; c < 24; c++) begin
            in_valid = (c % 2 == 0);
            env_in = $urandom;
            out_ready = (c % 2 == 1);
            @(posedge clk); #1;
        end
        drain();
        check("bubble_count", 32'(in_hs - dropped), 32'(out_hs));

        // Reset with two samples in flight.
        in_valid = 1'b1; env_in = 32'hABCD; out_ready = 1'b1;
        @(posedge clk); #1;
        env_in = 32'h77;
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("midreset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_log_out", 32'(log_out), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("midreset_no_stale", 32'(out_valid), 32'd0);
        end
        single(32'h3, 16'h0600);
        drain();

        // Randomized traffic; the scoreboard checks every output.
        acc = 0; cyc = 0; took = 1'b1; in_valid = 1'b0;
        while (acc < 10000 && cyc < 60000) begin
            if (took || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                env_in = $urandom >> $urandom_range(0, 32);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_accepted", 32'(acc), 32'd10000);
        drain();
        check("handshake_balance", 32'(in_hs - dropped), 32'(out_hs));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
